// File: rtl/stripe_scheduler.sv
// stripe_scheduler: accepts one job at a time, allocates a free stripe
// round-robin, writes its configuration, then issues the per-iteration
// operand tag pairs to the block-memory fetch port and reports completion.
module stripe_scheduler #(
  parameter int TAG_WIDTH    = 12,
  parameter int INSTR_WIDTH  = 7,
  parameter int NUM_STRIPES  = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [TAG_WIDTH-1:0]           job_tag_a,
  input  logic [TAG_WIDTH-1:0]           job_tag_b,
  input  logic [TAG_WIDTH-1:0]           job_stride_a,
  input  logic [TAG_WIDTH-1:0]           job_stride_b,
  input  logic [TAG_WIDTH-1:0]           job_iter_lim,
  input  logic [INSTR_WIDTH-1:0]         job_instr,
  input  logic [NUM_STRIPES-1:0]         release_mask,
  output logic [NUM_STRIPES-1:0]         cfg_we,
  output logic [TAG_WIDTH-1:0]           cfg_tag_a,
  output logic [TAG_WIDTH-1:0]           cfg_tag_b,
  output logic [TAG_WIDTH-1:0]           cfg_stride_a,
  output logic [TAG_WIDTH-1:0]           cfg_stride_b,
  output logic [TAG_WIDTH-1:0]           cfg_iter_lim,
  output logic [INSTR_WIDTH-1:0]         cfg_instr,
  output logic                           mem_req,
  input  logic                           mem_ready,
  output logic [TAG_WIDTH-1:0]           mem_tag_a,
  output logic [TAG_WIDTH-1:0]           mem_tag_b,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_STRIPES)-1:0] done_stripe,
  output logic [NUM_STRIPES-1:0]         alloc
);

  localparam int SW = $clog2(NUM_STRIPES);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONFIG = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]             state;
  logic [SW-1:0]          rr_ptr;
  logic [SW-1:0]          chosen;
  logic [TAG_WIDTH-1:0]   iter_cnt;
  logic [DW-1:0]          drain_cnt;
  logic [SW-1:0]          pick_idx;
  logic                   pick_found;
  logic [SW:0]            scan_sum;
  logic [SW-1:0]          scan_idx;
  logic [SW-1:0]          rr_next;
  logic [NUM_STRIPES-1:0] rel_eff;
  logic                   accept;
  logic                   last_iter;

  function automatic logic [NUM_STRIPES-1:0] onehot(input logic [SW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign job_ready   = (state == S_IDLE) && !(&alloc);
  assign accept      = job_valid && job_ready;
  assign busy        = (state != S_IDLE);
  assign mem_req     = (state == S_ISSUE);
  assign done        = (state == S_DONE);
  assign done_stripe = (state == S_DONE) ? chosen : '0;
  assign cfg_we      = (state == S_CONFIG) ? onehot(chosen) : '0;
  assign last_iter   = (iter_cnt == cfg_iter_lim - TAG_WIDTH'(1));
  assign rr_next     = (pick_idx == SW'(NUM_STRIPES - 1)) ? '0 : pick_idx + SW'(1);
  // The stripe owned by the running job cannot be freed under it.
  assign rel_eff     = release_mask & ~(busy ? onehot(chosen) : '0);

  // Scan for the first free stripe at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_STRIPES; i++) begin
      scan_sum = {1'b0, rr_ptr} + (SW+1)'(i);
      if (scan_sum >= (SW+1)'(NUM_STRIPES)) scan_sum = scan_sum - (SW+1)'(NUM_STRIPES);
      scan_idx = scan_sum[SW-1:0];
      if (!pick_found && !alloc[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Control: job sequencing, stripe allocation and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      alloc     <= '0;
      rr_ptr    <= '0;
      chosen    <= '0;
      iter_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      // Allocation uses the pre-edge mask, so a stripe freed now is not picked now.
      alloc <= (alloc & ~rel_eff) | ((accept && pick_found) ? onehot(pick_idx) : '0);
      case (state)
        S_IDLE: begin
          if (accept) begin
            chosen <= pick_idx;
            rr_ptr <= rr_next;
            state  <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          iter_cnt  <= '0;
          drain_cnt <= '0;
          state     <= (cfg_iter_lim != '0) ? S_ISSUE : S_DRAIN;
        end
        S_ISSUE: begin
          if (mem_ready) begin
            iter_cnt <= iter_cnt + TAG_WIDTH'(1);
            if (last_iter) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state <= S_DONE;
          else drain_cnt <= drain_cnt + DW'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: latched job fields and the running fetch tag pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_tag_a    <= '0;
      cfg_tag_b    <= '0;
      cfg_stride_a <= '0;
      cfg_stride_b <= '0;
      cfg_iter_lim <= '0;
      cfg_instr    <= '0;
      mem_tag_a    <= '0;
      mem_tag_b    <= '0;
    end else begin
      if (accept) begin
        cfg_tag_a    <= job_tag_a;
        cfg_tag_b    <= job_tag_b;
        cfg_stride_a <= job_stride_a;
        cfg_stride_b <= job_stride_b;
        cfg_iter_lim <= job_iter_lim;
        cfg_instr    <= job_instr;
      end
      if (state == S_CONFIG) begin
        mem_tag_a <= cfg_tag_a;
        mem_tag_b <= cfg_tag_b;
      end else if ((state == S_ISSUE) && mem_ready) begin
        mem_tag_a <= mem_tag_a + cfg_stride_a;
        mem_tag_b <= mem_tag_b + cfg_stride_b;
      end
    end
  end

endmodule

// File: tb/tb_stripe_scheduler.sv
// Bench for stripe_scheduler: directed scenarios plus randomized jobs,
// checked against an arithmetic model of tag sequences and stripe allocation.
module tb_stripe_scheduler;

  localparam int TW = 12;
  localparam int IW = 7;
  localparam int NS = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [TW-1:0] job_tag_a, job_tag_b, job_stride_a, job_stride_b, job_iter_lim;
  logic [IW-1:0] job_instr;
  logic [NS-1:0] release_mask;
  logic [NS-1:0] cfg_we;
  logic [TW-1:0] cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b, cfg_iter_lim;
  logic [IW-1:0] cfg_instr;
  logic          mem_req;
  logic          mem_ready;
  logic [TW-1:0] mem_tag_a, mem_tag_b;
  logic          busy;
  logic          done;
  logic [1:0]    done_stripe;
  logic [NS-1:0] alloc;

  always #5 clk = ~clk;

  stripe_scheduler #(
    .TAG_WIDTH(TW), .INSTR_WIDTH(IW), .NUM_STRIPES(NS), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_tag_a(job_tag_a), .job_tag_b(job_tag_b),
    .job_stride_a(job_stride_a), .job_stride_b(job_stride_b),
    .job_iter_lim(job_iter_lim), .job_instr(job_instr),
    .release_mask(release_mask), .cfg_we(cfg_we),
    .cfg_tag_a(cfg_tag_a), .cfg_tag_b(cfg_tag_b),
    .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b),
    .cfg_iter_lim(cfg_iter_lim), .cfg_instr(cfg_instr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_tag_a(mem_tag_a), .mem_tag_b(mem_tag_b),
    .busy(busy), .done(done), .done_stripe(done_stripe), .alloc(alloc)
  );

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [NS-1:0] model_alloc;
  int            model_rr;
  bit            rdy_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First free stripe at or after the round-robin pointer, wrapping.
  function automatic int model_pick();
    for (int i = 0; i < NS; i++) begin
      int c;
      c = (model_rr + i) % NS;
      if (!model_alloc[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [TW-1:0] exp_tag(input logic [TW-1:0] base, input logic [TW-1:0] stride,
                                            input int k);
    int v;
    v = int'(base) + k * int'(stride);
    return TW'(v);
  endfunction

  task automatic do_release(input logic [NS-1:0] m);
    release_mask = m;
    @(posedge clk); #1;
    release_mask = '0;
    model_alloc = model_alloc & ~m;
    check("release_alloc", 32'(alloc), 32'(model_alloc));
  endtask

  // rmode: 0 = mem_ready always high, 1 = rdy_q pattern then high, 2 = random
  task automatic run_job(input logic [TW-1:0] ta, input logic [TW-1:0] tb_, input logic [TW-1:0] sa,
                         input logic [TW-1:0] sb, input logic [TW-1:0] lim, input logic [IW-1:0] ins,
                         input logic [NS-1:0] rel_acc, input logic [NS-1:0] rel_mid, input int rmode);
    int            s, k, gap, cyc, budget;
    bit            mr, hs;
    logic [NS-1:0] oh;
    check("pre_alloc", 32'(alloc), 32'(model_alloc));
    check("job_ready_idle", 32'(job_ready), 32'(1));
    s = model_pick();
    job_tag_a = ta; job_tag_b = tb_; job_stride_a = sa; job_stride_b = sb;
    job_iter_lim = lim; job_instr = ins; job_valid = 1'b1; release_mask = rel_acc;
    @(posedge clk); #1;
    job_valid = 1'b0; release_mask = '0;
    oh = NS'(1) << s;
    model_alloc = (model_alloc & ~rel_acc) | oh;
    model_rr = (s + 1) % NS;
    check("cfg_we_config", 32'(cfg_we), 32'(oh));
    check("cfg_tag_a", 32'(cfg_tag_a), 32'(ta));
    check("cfg_tag_b", 32'(cfg_tag_b), 32'(tb_));
    check("cfg_stride_a", 32'(cfg_stride_a), 32'(sa));
    check("cfg_stride_b", 32'(cfg_stride_b), 32'(sb));
    check("cfg_iter_lim", 32'(cfg_iter_lim), 32'(lim));
    check("cfg_instr", 32'(cfg_instr), 32'(ins));
    check("busy_config", 32'(busy), 32'(1));
    check("job_ready_busy", 32'(job_ready), 32'(0));
    check("mem_req_config", 32'(mem_req), 32'(0));
    check("alloc_accept", 32'(alloc), 32'(model_alloc));
    release_mask = rel_mid;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    release_mask = '0;
    model_alloc = model_alloc & ~(rel_mid & ~oh);
    check("cfg_we_after", 32'(cfg_we), 32'(0));
    check("alloc_mid", 32'(alloc), 32'(model_alloc));
    k = 0; gap = 1; cyc = 0; budget = 4 * int'(lim) + 50;
    while (done !== 1'b1 && cyc < budget) begin
      mr = 1'($urandom_range(0, 1));
      if (mem_req === 1'b1) begin
        check("req_within_lim", 32'(k < int'(lim)), 32'(1));
        check("mem_tag_a", 32'(mem_tag_a), 32'(exp_tag(ta, sa, k)));
        check("mem_tag_b", 32'(mem_tag_b), 32'(exp_tag(tb_, sb, k)));
        if (rmode == 0) mr = 1'b1;
        else if (rmode == 1) mr = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      end
      hs = (mem_req === 1'b1) && mr;
      mem_ready = mr;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin k++; gap = 1; end
      else gap++;
    end
    mem_ready = 1'b0;
    check("done_seen", 32'(done), 32'(1));
    check("drain_len", 32'(gap), 32'(DC + 1));
    check("handshakes", 32'(k), 32'(lim));
    check("done_stripe", 32'(done_stripe), 32'(s));
    check("mem_req_done", 32'(mem_req), 32'(0));
    check("cfg_hold", 32'(cfg_tag_a), 32'(ta));
    check("alloc_done", 32'(alloc), 32'(model_alloc));
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'(0));
    check("busy_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; release_mask = '0; mem_ready = 1'b0;
    job_tag_a = '0; job_tag_b = '0; job_stride_a = '0; job_stride_b = '0;
    job_iter_lim = '0; job_instr = '0;
    model_alloc = '0; model_rr = 0;
    #3;
    check("rst_job_ready", 32'(job_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_alloc", 32'(alloc), 32'(0));
    check("rst_cfg_we", 32'(cfg_we), 32'(0));
    check("rst_cfg_tag_a", 32'(cfg_tag_a), 32'(0));
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_tag_a", 32'(mem_tag_a), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Basic job on stripe 0, then backpressure, tag wrap and zero-iteration jobs.
    run_job(12'h010, 12'h200, 12'h001, 12'h010, 12'd3, 7'h15, '0, '0, 0);
    rdy_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_job(12'h010, 12'h200, 12'h001, 12'h010, 12'd3, 7'h15, '0, '0, 1);
    run_job(12'hFFE, 12'h123, 12'h001, 12'h7FF, 12'd3, 7'h2A, '0, '0, 2);
    run_job(12'h055, 12'h0AA, 12'h003, 12'h005, 12'd0, 7'h01, '0, '0, 2);

    // All stripes allocated: jobs are held off and nothing starts.
    check("full_ready", 32'(job_ready), 32'(0));
    job_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("full_busy", 32'(busy), 32'(0));
      check("full_alloc", 32'(alloc), 32'(4'hF));
    end
    job_valid = 1'b0;

    do_release(4'b0100);
    run_job(12'h100, 12'h300, 12'h002, 12'h004, 12'd2, 7'h33, '0, '0, 0);
    // Stripe 3 is at the pointer but freed on the accept edge; stripe 0 is chosen.
    do_release(4'b0001);
    run_job(12'h400, 12'h500, 12'h001, 12'h001, 12'd2, 7'h44, 4'b1000, 4'b1111, 2);

    // Asynchronous reset after one handshake.
    job_tag_a = 12'h020; job_tag_b = 12'h030; job_stride_a = 12'h002; job_stride_b = 12'h003;
    job_iter_lim = 12'd5; job_instr = 7'h0F; job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_tag", 32'(mem_tag_a), 32'(12'h022));
    #2 rst = 1'b1;
    #1;
    check("ar_mem_req", 32'(mem_req), 32'(0));
    check("ar_busy", 32'(busy), 32'(0));
    check("ar_alloc", 32'(alloc), 32'(0));
    check("ar_mem_tag_a", 32'(mem_tag_a), 32'(0));
    check("ar_cfg_iter_lim", 32'(cfg_iter_lim), 32'(0));
    check("ar_job_ready", 32'(job_ready), 32'(1));
    mem_ready = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    model_alloc = '0; model_rr = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("ar_no_done", 32'(done), 32'(0));
    end
    run_job(12'h0C0, 12'h0D0, 12'h010, 12'h020, 12'd2, 7'h11, '0, '0, 0);

    // Maximum iteration count.
    run_job(12'h000, 12'h800, 12'h001, 12'h002, 12'hFFF, 7'h7F, '0, '0, 0);

    // Randomized jobs with random releases and backpressure.
    for (int j = 0; j < 25; j++) begin
      logic [NS-1:0] ra, rm;
      if ((&model_alloc) || $urandom_range(0, 3) == 0) do_release(NS'($urandom));
      if (&model_alloc) do_release(NS'(1) << $urandom_range(0, NS - 1));
      ra = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      rm = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      run_job(TW'($urandom), TW'($urandom), TW'($urandom), TW'($urandom),
              TW'($urandom_range(0, 6)), IW'($urandom), ra, rm, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stripe_scheduler.md
Name: stripe_scheduler

Overview:
- Sequences jobs onto an array of NUM_STRIPES stripe units.
- Accepts job descriptors over a valid/ready handshake and allocates a free stripe round-robin.
- Writes that stripe's configuration (tags, strides, iteration limit, instruction) with a one-cycle write strobe, then issues the per-iteration operand tag pairs to the block-memory fetch port.
- Signals completion once the pipeline drains; one job is in flight at a time.

Parameters:
TAG_WIDTH, 12, width of tags, strides and iteration counts
INSTR_WIDTH, 7, width of PE instruction word
NUM_STRIPES, 4, number of stripes managed (2..16)
DRAIN_CYCLES, 3, cycles waited after last issue before done (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
job_valid  in  1  job descriptor valid
job_ready  out  1  scheduler can accept job
job_tag_a  in  TAG_WIDTH  first operand A tag
job_tag_b  in  TAG_WIDTH  first operand B tag
job_stride_a  in  TAG_WIDTH  A tag increment per iteration
job_stride_b  in  TAG_WIDTH  B tag increment per iteration
job_iter_lim  in  TAG_WIDTH  iteration count
job_instr  in  INSTR_WIDTH  PE instruction
release  in  NUM_STRIPES  one-hot/multi-hot: host has read stripe results, free it
cfg_we  out  NUM_STRIPES  one-hot config write strobe (en_tag_write per stripe)
cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b, cfg_iter_lim  out  TAG_WIDTH each  latched job fields
cfg_instr  out  INSTR_WIDTH  latched instruction
mem_req  out  1  fetch request valid
mem_ready  in  1  fetch accepted
mem_tag_a, mem_tag_b  out  TAG_WIDTH  current iteration tags
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
done_stripe  out  clog2(NUM_STRIPES)  stripe that completed, valid with done
alloc  out  NUM_STRIPES  allocated-stripe mask

Behaviour:
- Reset: state IDLE; alloc=0, rr pointer=0, all counters and latched fields=0. Every output is 0, except job_ready, which is combinational (see IDLE).
- States: IDLE, CONFIG, ISSUE, DRAIN, DONE.
- IDLE:
  - job_ready = ~(&alloc) (combinational, IDLE only).
  - On job_valid & job_ready: latch all job fields.
  - Choose the first free stripe at or after the rr pointer, wrapping; set its alloc bit; rr pointer = chosen+1 mod NUM_STRIPES.
  - Go to CONFIG.
- CONFIG: exactly one cycle.
  - cfg_we = onehot(chosen); cfg_* hold the latched fields from CONFIG onward until the next accept.
  - Load iteration counter=0, mem_tag_a=tag_a, mem_tag_b=tag_b.
  - Next: ISSUE if iter_lim!=0, else DRAIN.
- ISSUE:
  - mem_req=1; tags held stable while mem_req & ~mem_ready.
  - On handshake: counter++, mem_tag_a += stride_a, mem_tag_b += stride_b (modulo 2^TAG_WIDTH wrap, no saturation).
  - Handshake with counter==iter_lim-1 -> DRAIN; mem_req deasserts next cycle.
  - Exactly iter_lim handshakes per job.
- DRAIN: count DRAIN_CYCLES cycles, then DONE.
- DONE: one cycle, done=1, done_stripe=chosen; -> IDLE. The stripe stays allocated until released.
- Release:
  - Applies at the clock edge: alloc &= ~release.
  - Bits for unallocated stripes are ignored.
  - Bit for the active stripe (state CONFIG..DONE) is ignored.
- Simultaneous release and accept in IDLE: allocation uses the pre-edge alloc mask. A stripe freed this cycle is not eligible until the next cycle; the other freed bits clear normally.
- All stripes allocated: job_ready=0; the scheduler waits in IDLE.
- Async reset mid-job: immediate return to reset values. No done is emitted, and the stripe's state is the host's responsibility.
- job_valid while not in IDLE is ignored (job_ready=0).
- iter_lim = 2^TAG_WIDTH-1 is legal; the counter must not overflow before compare.

Test Plan:
- Reset then single job: tag_a=0x010, tag_b=0x200, stride_a=1, stride_b=0x10, iter_lim=3, mem_ready=1 -> cfg_we=0001 for 1 cycle; mem tags (0x010,0x200),(0x011,0x210),(0x012,0x220); done after 3 DRAIN cycles with done_stripe=0; alloc=0001.
- Backpressure: same job, mem_ready toggles 0,0,1,0,1,1 -> tags stable while stalled; exactly 3 handshakes; no skipped or duplicated tag pair.
- Wrap: tag_a=0xFFE, stride_a=1, iter_lim=3 -> mem_tag_a sequence 0xFFE,0xFFF,0x000.
- iter_lim=0 -> CONFIG then DRAIN; mem_req never asserted; done pulse 1+DRAIN_CYCLES cycles after CONFIG.
- Allocation: 4 jobs without release -> stripes 0,1,2,3 and job_ready=0; release=0100 -> next job gets stripe 2; release with simultaneous accept in IDLE -> freed stripe not chosen that cycle.
- Async reset asserted during ISSUE after 1 handshake -> outputs zero immediately; no done; alloc=0; next job gets stripe 0.
